// File: rtl/pueo_trig_pkg.sv
// Shared types and helpers for the PUEO multi-source trigger front end.
// Holds the output record layout, hold-timer states and the round-robin picker.
package pueo_trig_pkg;

    localparam int unsigned META_VALID_BIT = 7;
    localparam int unsigned SEQ_W          = 7;
    localparam int unsigned DROP_W         = 16;
    localparam int unsigned REC_ADDR_W     = 16;
    localparam int unsigned REC_SRC_W      = 4;

    typedef struct packed {
        logic [REC_ADDR_W-1:0] addr;
        logic [REC_SRC_W-1:0]  src;
        logic [SEQ_W-1:0]      seq;
    } trig_rec_t;

    typedef enum logic {
        HOLD_IDLE,
        HOLD_ACTIVE
    } hold_state_e;

    // First requester after 'last', wrapping modulo nchan; returns 'last' if none.
    function automatic logic [3:0] rr_pick(input logic [15:0] req,
                                           input logic [3:0]  last,
                                           input int unsigned nchan);
        logic [3:0]  pick;
        logic        found;
        int unsigned idx;
        pick  = last;
        found = 1'b0;
        for (int unsigned i = 1; i <= 16; i++) begin
            idx = 32'(last) + i;
            if (idx >= nchan) idx = idx - nchan;
            if (!found && i <= nchan && req[idx[3:0]]) begin
                pick  = idx[3:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/pueo_trig_src_chan.sv
// One trigger source: synchronizer, edge detect, prescale, holdoff,
// pending flag with offset-corrected address capture, sequence and drop counters.
module pueo_trig_src_chan
    import pueo_trig_pkg::*;
#(
    parameter int unsigned ADDR_W     = 12,
    parameter int unsigned OFS_W      = 16,
    parameter int unsigned PRESCALE_W = 16,
    parameter int unsigned HOLDOFF_W  = 16
) (
    input  logic                  sysclk_i,
    input  logic                  sysclk_rstn_i,
    input  logic                  running_i,
    input  logic [ADDR_W-1:0]     cur_addr_i,
    input  logic                  trig_in_i,
    input  logic                  en_i,
    input  logic [OFS_W-1:0]      offset_i,
    input  logic [PRESCALE_W-1:0] prescale_i,
    input  logic [HOLDOFF_W-1:0]  holdoff_i,
    input  logic                  cfg_update_i,
    input  logic                  grant_i,
    input  logic                  seq_inc_i,
    output logic                  pending_o,
    output logic [ADDR_W-1:0]     addr_o,
    output logic [SEQ_W-1:0]      seq_o,
    output logic [DROP_W-1:0]     drop_cnt_o
);

    logic [2:0]            trig_sync_q;
    logic [1:0]            en_sync_q;
    logic [PRESCALE_W-1:0] pre_cnt_q;
    logic [HOLDOFF_W-1:0]  holdoff_cnt_q;
    logic                  edge_det;
    logic                  qual;
    logic                  to_pre;
    logic                  drop;
    logic                  fire;
    logic                  ofs_unused;

    assign edge_det   = trig_sync_q[1] & ~trig_sync_q[2];
    assign qual       = edge_det & en_sync_q[1] & running_i;
    assign to_pre     = qual && (holdoff_cnt_q == '0) && !pending_o;
    assign drop       = qual && (holdoff_cnt_q == '0) && pending_o;
    assign fire       = to_pre && (pre_cnt_q == '0);
    assign ofs_unused = ^offset_i;

    always_ff @(posedge sysclk_i or negedge sysclk_rstn_i) begin
        if (!sysclk_rstn_i) begin
            trig_sync_q <= '0;
            en_sync_q   <= '0;
        end else begin
            trig_sync_q <= {trig_sync_q[1:0], trig_in_i};
            en_sync_q   <= {en_sync_q[0], en_i};
        end
    end

    always_ff @(posedge sysclk_i or negedge sysclk_rstn_i) begin
        if (!sysclk_rstn_i) begin
            pre_cnt_q <= '0;
        end else if (cfg_update_i || !running_i) begin
            pre_cnt_q <= prescale_i;
        end else if (to_pre) begin
            pre_cnt_q <= fire ? prescale_i : pre_cnt_q - PRESCALE_W'(1);
        end
    end

    // Fire only happens with pending low and grant only with pending high, so they never collide.
    always_ff @(posedge sysclk_i or negedge sysclk_rstn_i) begin
        if (!sysclk_rstn_i) begin
            pending_o     <= 1'b0;
            addr_o        <= '0;
            holdoff_cnt_q <= '0;
            seq_o         <= '0;
            drop_cnt_o    <= '0;
        end else if (!running_i) begin
            pending_o     <= 1'b0;
            holdoff_cnt_q <= '0;
            seq_o         <= '0;
            drop_cnt_o    <= '0;
        end else begin
            if (fire) begin
                pending_o     <= 1'b1;
                addr_o        <= cur_addr_i - offset_i[ADDR_W-1:0];
                holdoff_cnt_q <= holdoff_i;
            end else begin
                if (grant_i) pending_o <= 1'b0;
                if (holdoff_cnt_q != '0) holdoff_cnt_q <= holdoff_cnt_q - HOLDOFF_W'(1);
            end
            if (drop && (drop_cnt_o != '1)) drop_cnt_o <= drop_cnt_o + DROP_W'(1);
            if (seq_inc_i) seq_o <= seq_o + SEQ_W'(1);
        end
    end

endmodule

// File: rtl/pueo_trig_src_mux.sv
// Multi-source trigger front end: per-channel qualification, then a round-robin
// grant once per sysclk phase period into a held, phase-aligned output record.
module pueo_trig_src_mux
    import pueo_trig_pkg::*;
#(
    parameter int unsigned NCHAN      = 4,
    parameter int unsigned ADDR_W     = 12,
    parameter int unsigned OFS_W      = 16,
    parameter int unsigned PRESCALE_W = 16,
    parameter int unsigned HOLDOFF_W  = 16,
    parameter int unsigned PHASE_LEN  = 8,
    parameter int unsigned CAP_PHASE  = 2,
    parameter int unsigned HOLD_LEN   = 4,
    localparam int unsigned SRC_W     = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
    input  logic                        sysclk_i,
    input  logic                        sysclk_rstn_i,
    input  logic                        sysclk_phase_i,
    input  logic                        running_i,
    input  logic [ADDR_W-1:0]           cur_addr_i,
    input  logic [NCHAN-1:0]            trig_in_i,
    input  logic [NCHAN-1:0]            en_i,
    input  logic [NCHAN*OFS_W-1:0]      offset_i,
    input  logic [NCHAN*PRESCALE_W-1:0] prescale_i,
    input  logic [NCHAN*HOLDOFF_W-1:0]  holdoff_i,
    input  logic                        cfg_update_i,
    output logic [ADDR_W-1:0]           trig_addr_o,
    output logic [7:0]                  trig_meta_o,
    output logic [SRC_W-1:0]            trig_src_o,
    output logic                        trig_valid_o,
    output logic [NCHAN*DROP_W-1:0]     drop_cnt_o
);

    localparam int unsigned PH_W = (PHASE_LEN > 1) ? $clog2(PHASE_LEN) : 1;
    localparam int unsigned HC_W = $clog2(HOLD_LEN + 1);

    logic [PH_W-1:0]   phase_q;
    hold_state_e       state_q, state_d;
    logic [HC_W-1:0]   hold_q, hold_d;
    logic [SRC_W-1:0]  last_q;
    logic [SRC_W-1:0]  sel;
    trig_rec_t         rec_q;
    logic              grant;
    logic              seq_inc;
    logic [15:0]       req_pad;
    logic [NCHAN-1:0]  pend;
    logic [NCHAN-1:0]  grant_vec;
    logic [NCHAN-1:0]  seq_inc_vec;
    logic [ADDR_W-1:0] chan_addr [NCHAN];
    logic [SEQ_W-1:0]  chan_seq  [NCHAN];
    logic              rec_unused;

    for (genvar g = 0; g < NCHAN; g++) begin : g_chan
        assign grant_vec[g]   = grant && (sel == SRC_W'(g));
        assign seq_inc_vec[g] = seq_inc && (rec_q.src == REC_SRC_W'(g));

        pueo_trig_src_chan #(
            .ADDR_W     (ADDR_W),
            .OFS_W      (OFS_W),
            .PRESCALE_W (PRESCALE_W),
            .HOLDOFF_W  (HOLDOFF_W)
        ) u_chan (
            .sysclk_i      (sysclk_i),
            .sysclk_rstn_i (sysclk_rstn_i),
            .running_i     (running_i),
            .cur_addr_i    (cur_addr_i),
            .trig_in_i     (trig_in_i[g]),
            .en_i          (en_i[g]),
            .offset_i      (offset_i[g*OFS_W +: OFS_W]),
            .prescale_i    (prescale_i[g*PRESCALE_W +: PRESCALE_W]),
            .holdoff_i     (holdoff_i[g*HOLDOFF_W +: HOLDOFF_W]),
            .cfg_update_i  (cfg_update_i),
            .grant_i       (grant_vec[g]),
            .seq_inc_i     (seq_inc_vec[g]),
            .pending_o     (pend[g]),
            .addr_o        (chan_addr[g]),
            .seq_o         (chan_seq[g]),
            .drop_cnt_o    (drop_cnt_o[g*DROP_W +: DROP_W])
        );
    end

    always_ff @(posedge sysclk_i or negedge sysclk_rstn_i) begin
        if (!sysclk_rstn_i) begin
            phase_q <= '0;
        end else if (sysclk_phase_i) begin
            phase_q <= '0;
        end else if (phase_q != PH_W'(PHASE_LEN - 1)) begin
            phase_q <= phase_q + PH_W'(1);
        end
    end

    always_comb begin
        req_pad = '0;
        req_pad[NCHAN-1:0] = pend;
        sel = SRC_W'(rr_pick(req_pad, 4'(last_q), NCHAN));
    end

    // Hold window runs off its own counter; the phase only gates when a grant may start.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        grant   = 1'b0;
        seq_inc = 1'b0;
        case (state_q)
            HOLD_IDLE: begin
                if (phase_q == PH_W'(CAP_PHASE) && running_i && (pend != '0)) begin
                    grant   = 1'b1;
                    state_d = HOLD_ACTIVE;
                    hold_d  = '0;
                end
            end
            HOLD_ACTIVE: begin
                if (hold_q == HC_W'(HOLD_LEN - 1)) begin
                    state_d = HOLD_IDLE;
                    seq_inc = 1'b1;
                end else begin
                    hold_d = hold_q + HC_W'(1);
                end
            end
            default: state_d = HOLD_IDLE;
        endcase
    end

    always_ff @(posedge sysclk_i or negedge sysclk_rstn_i) begin
        if (!sysclk_rstn_i) begin
            state_q <= HOLD_IDLE;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    always_ff @(posedge sysclk_i or negedge sysclk_rstn_i) begin
        if (!sysclk_rstn_i) begin
            last_q <= SRC_W'(NCHAN - 1);
            rec_q  <= '0;
        end else begin
            if (!running_i) begin
                last_q <= SRC_W'(NCHAN - 1);
            end else if (grant) begin
                last_q <= sel;
            end
            if (grant) begin
                rec_q.addr <= REC_ADDR_W'(chan_addr[sel]);
                rec_q.src  <= REC_SRC_W'(sel);
                rec_q.seq  <= chan_seq[sel];
            end
        end
    end

    assign trig_addr_o  = rec_q.addr[ADDR_W-1:0];
    assign trig_src_o   = rec_q.src[SRC_W-1:0];
    assign trig_valid_o = (state_q == HOLD_ACTIVE);
    assign rec_unused   = ^{rec_q.addr, rec_q.src};

    always_comb begin
        trig_meta_o = '0;
        trig_meta_o[SEQ_W-1:0] = rec_q.seq;
        trig_meta_o[META_VALID_BIT] = 1'b1;
    end

endmodule

// File: tb/tb_pueo_trig_src_mux.sv
// Directed bench for pueo_trig_src_mux: expected grant records are queued as
// pulses are driven and checked against each valid window as it appears.
module tb_pueo_trig_src_mux;

    logic        clk;
    logic        rstn;
    logic        sysclk_phase_i;
    logic        running_i;
    logic [11:0] cur_addr_i;
    logic [3:0]  trig_in_i;
    logic [3:0]  en_i;
    logic [63:0] offset_i;
    logic [63:0] prescale_i;
    logic [63:0] holdoff_i;
    logic        cfg_update_i;
    logic [11:0] trig_addr_o;
    logic [7:0]  trig_meta_o;
    logic [1:0]  trig_src_o;
    logic        trig_valid_o;
    logic [63:0] drop_cnt_o;

    typedef struct {
        logic [11:0] addr;
        logic [7:0]  meta;
        logic [1:0]  src;
    } exp_t;

    exp_t        sb[$];
    exp_t        cur;
    logic [6:0]  seq_exp [4];
    logic [11:0] offs [4];
    int          ntests = 0;
    int          nfail  = 0;
    int unsigned cyc    = 0;
    int unsigned since_ph = 0;
    int unsigned hlen   = 0;
    logic        prev_v = 1'b0;

    pueo_trig_src_mux #(
        .NCHAN      (4),
        .ADDR_W     (12),
        .OFS_W      (16),
        .PRESCALE_W (16),
        .HOLDOFF_W  (16),
        .PHASE_LEN  (8),
        .CAP_PHASE  (2),
        .HOLD_LEN   (4)
    ) dut (
        .sysclk_i       (clk),
        .sysclk_rstn_i  (rstn),
        .sysclk_phase_i (sysclk_phase_i),
        .running_i      (running_i),
        .cur_addr_i     (cur_addr_i),
        .trig_in_i      (trig_in_i),
        .en_i           (en_i),
        .offset_i       (offset_i),
        .prescale_i     (prescale_i),
        .holdoff_i      (holdoff_i),
        .cfg_update_i   (cfg_update_i),
        .trig_addr_o    (trig_addr_o),
        .trig_meta_o    (trig_meta_o),
        .trig_src_o     (trig_src_o),
        .trig_valid_o   (trig_valid_o),
        .drop_cnt_o     (drop_cnt_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        sysclk_phase_i = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            sysclk_phase_i = (cyc % 8 == 0);
        end
    end

    // Phase index as the grant logic should see it after each edge.
    initial begin
        forever begin
            @(posedge clk);
            if (!rstn) since_ph = 0;
            else if (sysclk_phase_i) since_ph = 0;
            else if (since_ph < 7) since_ph++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!rstn) begin
                prev_v = 1'b0;
                hlen   = 0;
            end else begin
                if (trig_valid_o && !prev_v) begin
                    check("grant_phase", since_ph, 3);
                    check("grant_expected", {31'b0, sb.size() != 0}, 1);
                    if (sb.size() != 0) cur = sb.pop_front();
                    hlen = 1;
                    check("addr", {20'b0, trig_addr_o}, {20'b0, cur.addr});
                    check("meta", {24'b0, trig_meta_o}, {24'b0, cur.meta});
                    check("src", {30'b0, trig_src_o}, {30'b0, cur.src});
                end else if (trig_valid_o) begin
                    hlen++;
                    check("hold_stable", {trig_addr_o, trig_meta_o, trig_src_o},
                          {cur.addr, cur.meta, cur.src});
                end else if (prev_v) begin
                    check("hold_len", hlen, 4);
                end
                prev_v = trig_valid_o;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic cycles(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int ch);
        exp_t e;
        e.addr = cur_addr_i - offs[ch];
        e.meta = {1'b1, seq_exp[ch]};
        e.src  = 2'(ch);
        seq_exp[ch] = seq_exp[ch] + 7'd1;
        sb.push_back(e);
    endtask

    task automatic pulse(input logic [3:0] mask);
        trig_in_i = mask;
        cycles(2);
        trig_in_i = '0;
    endtask

    task automatic toggle_run();
        running_i = 1'b0;
        cycles(3);
        running_i = 1'b1;
        for (int i = 0; i < 4; i++) seq_exp[i] = '0;
        cycles(2);
    endtask

    task automatic drain(input int unsigned max);
        int unsigned n = 0;
        while ((sb.size() != 0 || trig_valid_o) && n < max) begin
            cycles(1);
            n++;
        end
        check("drain_in_time", {31'b0, n < max}, 1);
        cycles(2);
    endtask

    task automatic wait_valid(input int unsigned max);
        int unsigned n = 0;
        while (!trig_valid_o && n < max) begin
            cycles(1);
            n++;
        end
        check("valid_in_time", {31'b0, trig_valid_o}, 1);
    endtask

    initial begin
        int unsigned n;
        rstn         = 1'b0;
        running_i    = 1'b1;
        cur_addr_i   = 12'h003;
        trig_in_i    = '0;
        en_i         = 4'hF;
        offs[0] = 12'h005; offs[1] = 12'h001; offs[2] = 12'h010; offs[3] = 12'h800;
        offset_i     = {16'h0800, 16'h0010, 16'h0001, 16'h0005};
        prescale_i   = '0;
        holdoff_i    = '0;
        cfg_update_i = 1'b0;
        for (int i = 0; i < 4; i++) seq_exp[i] = '0;
        #1;
        check("rst_addr", {20'b0, trig_addr_o}, 0);
        check("rst_meta", {24'b0, trig_meta_o}, 32'h80);
        check("rst_src", {30'b0, trig_src_o}, 0);
        check("rst_valid", {31'b0, trig_valid_o}, 0);
        check("rst_drop", drop_cnt_o[31:0] | drop_cnt_o[63:32], 0);
        cycles(3);
        rstn = 1'b1;
        cycles(20);

        // 1: single pulse, address wraps below zero
        push(0);
        pulse(4'b0001);
        drain(60);

        // 2: all channels together, two full rounds starting at ch0
        toggle_run();
        cur_addr_i = 12'h100;
        push(0); push(1); push(2); push(3);
        pulse(4'b1111);
        drain(100);
        push(0); push(1); push(2); push(3);
        pulse(4'b1111);
        drain(100);
        check("drop_t2", drop_cnt_o[31:0] | drop_cnt_o[63:32], 0);

        // 3: prescale 2 on ch1 (counter reloaded by the run toggle)
        prescale_i[16 +: 16] = 16'd2;
        toggle_run();
        cur_addr_i = 12'h234;
        for (int k = 1; k <= 9; k++) begin
            if (k % 3 == 0) push(1);
            pulse(4'b0010);
            cycles(18);
        end
        drain(60);
        check("drop_t3", {16'b0, drop_cnt_o[16 +: 16]}, 0);
        prescale_i[16 +: 16] = 16'd0;

        // 4a: holdoff 100 swallows the second pulse silently
        holdoff_i[48 +: 16] = 16'd100;
        cur_addr_i = 12'h7FF;
        push(3);
        pulse(4'b1000);
        cycles(48);
        pulse(4'b1000);
        cycles(120);
        check("t4a_sb_empty", sb.size(), 0);
        check("t4a_drop", {16'b0, drop_cnt_o[48 +: 16]}, 0);
        holdoff_i[48 +: 16] = 16'd0;

        // 4b: two edges before one capture point -> one grant, one drop
        n = 0;
        while (!sysclk_phase_i && n < 16) begin
            cycles(1);
            n++;
        end
        cycles(3);
        push(3);
        trig_in_i = 4'b1000; cycles(1);
        trig_in_i = 4'b0000; cycles(1);
        trig_in_i = 4'b1000; cycles(1);
        trig_in_i = 4'b0000;
        cycles(20);
        drain(60);
        check("t4b_drop", {16'b0, drop_cnt_o[48 +: 16]}, 1);

        // 5: 129 grants on ch2, seq wraps back to 0x80
        toggle_run();
        for (int k = 0; k < 129; k++) begin
            cur_addr_i = 12'(k * 37);
            push(2);
            pulse(4'b0100);
            cycles(14);
        end
        drain(60);
        check("t5_seq_wrapped", {25'b0, seq_exp[2]}, 1);

        // 5b: running drops mid-hold; ch2 pending must be discarded
        cur_addr_i = 12'h555;
        push(1);
        pulse(4'b0110);
        wait_valid(40);
        cycles(1);
        running_i = 1'b0;
        for (int i = 0; i < 4; i++) seq_exp[i] = '0;
        cycles(40);
        running_i = 1'b1;
        cycles(30);
        check("t5b_no_stale", sb.size(), 0);
        push(2);
        pulse(4'b0100);
        drain(60);

        // 6: cfg_update reload of a prescale counter holding 5
        prescale_i[0 +: 16] = 16'd5;
        cur_addr_i = 12'h0A0;
        push(0);
        pulse(4'b0001);
        drain(60);
        prescale_i[0 +: 16] = 16'd0;
        cfg_update_i = 1'b1;
        cycles(1);
        cfg_update_i = 1'b0;
        cycles(2);
        push(0);
        pulse(4'b0001);
        drain(60);

        // 6b: async reset in the middle of a hold window
        cur_addr_i = 12'h123;
        push(0);
        pulse(4'b0001);
        wait_valid(40);
        cycles(2);
        rstn = 1'b0;
        #1;
        check("rst_mid_valid", {31'b0, trig_valid_o}, 0);
        check("rst_mid_addr", {20'b0, trig_addr_o}, 0);
        check("rst_mid_meta", {24'b0, trig_meta_o}, 32'h80);
        check("rst_mid_src", {30'b0, trig_src_o}, 0);
        cycles(3);
        rstn = 1'b1;
        cycles(5);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
